// File: rtl/icache_mem_responder_pkg.sv
// Shared types and constants for the instruction-cache miss responder.
// Default cache geometry is supplied here when the surrounding build does not
// define it: 256-bit lines, 6-bit index, 6-bit tag, 32-bit PC.
// Contents: icmemState_t (FSM states), ICMEM_BEATS (beats per line at the
// default 64-bit memory width) and icmemBeats() for other beat widths.

`ifndef ICACHE_BITS_IN_LINE
`define ICACHE_BITS_IN_LINE 256
`endif
`ifndef ICACHE_INDEX_BITS
`define ICACHE_INDEX_BITS 6
`endif
`ifndef ICACHE_TAG_BITS
`define ICACHE_TAG_BITS 6
`endif
`ifndef ICACHE_BLOCK_ADDR_BITS
`define ICACHE_BLOCK_ADDR_BITS (`ICACHE_TAG_BITS + `ICACHE_INDEX_BITS)
`endif
`ifndef SIZE_PC
`define SIZE_PC 32
`endif

package icache_mem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      RESPOND = 2'd2
   } icmemState_t;

   localparam int unsigned ICMEM_MEM_DATA_W = 64;
   localparam int unsigned ICMEM_BEATS      = `ICACHE_BITS_IN_LINE / ICMEM_MEM_DATA_W;

   // Beats needed to move one line over a memory port of the given width.
   function automatic int unsigned icmemBeats(input int unsigned memDataW);
      return `ICACHE_BITS_IN_LINE / memDataW;
   endfunction

endpackage

// File: rtl/icmem_req_fifo.sv
// Miss-request queue for icache_mem_responder.
// Ports: clk, reset (async, active-high); push/pushAddr enqueue, pop dequeues.
// headAddr_c/empty_c/full_c describe the head and fill state; entryAddr_c and
// entryValid_c expose every slot so the parent can run its duplicate compare.
// A push while full is taken only when a pop happens in the same cycle.

module icmem_req_fifo #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 12
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           push,
   input  logic [ADDR_W-1:0]              pushAddr,
   input  logic                           pop,
   output logic [ADDR_W-1:0]              headAddr_c,
   output logic                           empty_c,
   output logic                           full_c,
   output logic [DEPTH-1:0][ADDR_W-1:0]   entryAddr_c,
   output logic [DEPTH-1:0]               entryValid_c
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]              wrPtr;
   logic [PTR_W-1:0]              rdPtr;
   logic [DEPTH-1:0][ADDR_W-1:0]  slots;
   logic [DEPTH-1:0]              slotValid;
   logic                          doPop;
   logic                          doPush;

   assign empty_c      = ~|slotValid;
   assign full_c       = &slotValid;
   assign headAddr_c   = slots[rdPtr];
   assign entryAddr_c  = slots;
   assign entryValid_c = slotValid;

   assign doPop  = pop && !empty_c;
   assign doPush = push && (!full_c || doPop);

   // Pop clears first; a simultaneous push into the same slot re-sets it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         slots     <= '0;
         slotValid <= '0;
      end else begin
         if (doPop) begin
            slotValid[rdPtr] <= 1'b0;
            rdPtr            <= rdPtr + PTR_W'(1);
         end
         if (doPush) begin
            slots[wrPtr]     <= pushAddr;
            slotValid[wrPtr] <= 1'b1;
            wrPtr            <= wrPtr + PTR_W'(1);
         end
      end
   end

endmodule

// File: rtl/icache_mem_responder.sv
// Instruction-cache miss responder: queues line-miss requests, fetches each
// line from backing memory beat by beat and returns it as a one-cycle response.
// Ports: clk/reset; ic2memReq* (miss requests in); mem2ic* (line response and
// invalidation out); snoopWr* (memory write snoop in); memRd* (beat read port);
// reqDropped_o (sticky queue-overflow flag).
// Optional feature: define ICMEM_SNOOP_INV_EN to turn memory-write snoops into
// invalidations and to suppress the response of a line written while in flight.

module icache_mem_responder
   import icache_mem_responder_pkg::*;
#(
   parameter int unsigned QUEUE_DEPTH = 4,
   parameter int unsigned MEM_DATA_W  = 64
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [`ICACHE_BLOCK_ADDR_BITS-1:0]  ic2memReqAddr_i,
   input  logic                                ic2memReqValid_i,
   output logic [`ICACHE_TAG_BITS-1:0]         mem2icTag_o,
   output logic [`ICACHE_INDEX_BITS-1:0]       mem2icIndex_o,
   output logic [`ICACHE_BITS_IN_LINE-1:0]     mem2icData_o,
   output logic                                mem2icRespValid_o,
   output logic                                mem2icInv_o,
   output logic [`ICACHE_INDEX_BITS-1:0]       mem2icInvInd_o,
   output logic                                mem2icInvWay_o,
   input  logic [`ICACHE_BLOCK_ADDR_BITS-1:0]  snoopWrAddr_i,
   input  logic                                snoopWrValid_i,
   output logic [`SIZE_PC-1:0]                 memRdAddr_o,
   output logic                                memRdReq_o,
   input  logic                                memRdValid_i,
   input  logic [MEM_DATA_W-1:0]               memRdData_i,
   output logic                                reqDropped_o
);

   localparam int unsigned IDX_W      = `ICACHE_INDEX_BITS;
   localparam int unsigned BLK_W      = `ICACHE_BLOCK_ADDR_BITS;
   localparam int unsigned PC_W       = `SIZE_PC;
   localparam int unsigned LINE_W     = `ICACHE_BITS_IN_LINE;
   localparam int unsigned BEATS      = icmemBeats(MEM_DATA_W);
   localparam int unsigned BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned OFF_W      = $clog2(LINE_W / 8);
   localparam int unsigned BEAT_BYTES = MEM_DATA_W / 8;

   icmemState_t                        state;
   logic [BLK_W-1:0]                   curLine;
   logic [BEAT_W-1:0]                  beatCnt;
   logic [BEATS-1:0][MEM_DATA_W-1:0]   lineBuf;
   logic [BEATS-1:0][MEM_DATA_W-1:0]   nextBuf;
   logic                               finalBeat;
   logic                               respSuppress;

   logic [BLK_W-1:0]                   qHead;
   logic                               qEmpty;
   logic                               qFull;
   logic [QUEUE_DEPTH-1:0][BLK_W-1:0]  qAddr;
   logic [QUEUE_DEPTH-1:0]             qValid;
   logic [QUEUE_DEPTH-1:0]             qHit;
   logic                               dupHit;
   logic                               qPop;
   logic                               qPush;
   logic                               qDrop;

   // Byte address of a beat: line address followed by the in-line byte offset.
   function automatic logic [PC_W-1:0] beatAddr(input logic [BLK_W-1:0]  line,
                                                input logic [BEAT_W-1:0] beat);
      logic [OFF_W-1:0] off;
      off = OFF_W'(32'(beat) * BEAT_BYTES);
      return PC_W'({line, off});
   endfunction

   // Duplicate filter: a request matching any queued or in-flight line is dropped silently.
   for (genvar g = 0; g < QUEUE_DEPTH; g++) begin : gHit
      assign qHit[g] = qValid[g] && (qAddr[g] == ic2memReqAddr_i);
   end
   assign dupHit = (|qHit) || ((state != IDLE) && (ic2memReqAddr_i == curLine));

   assign qPop  = (state == IDLE) && !qEmpty;
   assign qPush = ic2memReqValid_i && !dupHit;
   assign qDrop = qPush && qFull && !qPop;

   icmem_req_fifo #(
      .DEPTH  (QUEUE_DEPTH),
      .ADDR_W (BLK_W)
   ) uReqFifo (
      .clk          (clk),
      .reset        (reset),
      .push         (qPush),
      .pushAddr     (ic2memReqAddr_i),
      .pop          (qPop),
      .headAddr_c   (qHead),
      .empty_c      (qEmpty),
      .full_c       (qFull),
      .entryAddr_c  (qAddr),
      .entryValid_c (qValid)
   );

   // Line buffer with the current beat merged in, so the last beat lands in the response directly.
   always_comb begin
      nextBuf          = lineBuf;
      nextBuf[beatCnt] = memRdData_i;
   end

   assign finalBeat      = (beatCnt == BEAT_W'(BEATS - 1));
   assign mem2icInvWay_o = 1'b0;

   // Fetch sequencer with registered response and memory-port outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= IDLE;
         curLine           <= '0;
         beatCnt           <= '0;
         lineBuf           <= '0;
         memRdAddr_o       <= '0;
         memRdReq_o        <= 1'b0;
         mem2icRespValid_o <= 1'b0;
         mem2icTag_o       <= '0;
         mem2icIndex_o     <= '0;
         mem2icData_o      <= '0;
         reqDropped_o      <= 1'b0;
      end else begin
         mem2icRespValid_o <= 1'b0;
         if (qDrop) begin
            reqDropped_o <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (!qEmpty) begin
                  state       <= FETCH;
                  curLine     <= qHead;
                  beatCnt     <= '0;
                  memRdAddr_o <= beatAddr(qHead, '0);
                  memRdReq_o  <= 1'b1;
               end
            end
            FETCH: begin
               if (memRdValid_i) begin
                  lineBuf <= nextBuf;
                  if (finalBeat) begin
                     state             <= RESPOND;
                     memRdReq_o        <= 1'b0;
                     mem2icRespValid_o <= !respSuppress;
                     mem2icTag_o       <= curLine[BLK_W-1:IDX_W];
                     mem2icIndex_o     <= curLine[IDX_W-1:0];
                     mem2icData_o      <= nextBuf;
                  end else begin
                     beatCnt     <= beatCnt + BEAT_W'(1);
                     memRdAddr_o <= beatAddr(curLine, beatCnt + BEAT_W'(1));
                  end
               end
            end
            RESPOND: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef ICMEM_SNOOP_INV_EN
   logic poisoned;
   logic snoopHit;

   // A write to the line being fetched makes its data stale; the response is withheld.
   assign snoopHit     = snoopWrValid_i && (state == FETCH) && (snoopWrAddr_i == curLine);
   assign respSuppress = poisoned || snoopHit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         poisoned       <= 1'b0;
         mem2icInv_o    <= 1'b0;
         mem2icInvInd_o <= '0;
      end else begin
         mem2icInv_o <= snoopWrValid_i;
         if (snoopWrValid_i) begin
            mem2icInvInd_o <= snoopWrAddr_i[IDX_W-1:0];
         end
         if (state == IDLE) begin
            poisoned <= 1'b0;
         end else if (snoopHit) begin
            poisoned <= 1'b1;
         end
      end
   end
`else
   logic unusedSnoop;

   assign respSuppress   = 1'b0;
   assign mem2icInv_o    = 1'b0;
   assign mem2icInvInd_o = '0;
   assign unusedSnoop    = ^{snoopWrAddr_i, snoopWrValid_i};
`endif

endmodule

// File: tb/tb_icache_mem_responder.sv
// Self-checking bench for icache_mem_responder (default geometry: 256-bit
// line, 64-bit beats, 6-bit tag, 6-bit index, 32-bit PC).
// The memory model returns {addr ^ 32'hA5A50000, addr} for each beat address.

module tb_icache_mem_responder;

   logic         clk;
   logic         reset;
   logic [11:0]  reqAddr;
   logic         reqValid;
   logic [5:0]   respTag;
   logic [5:0]   respIndex;
   logic [255:0] respData;
   logic         respValid;
   logic         inv;
   logic [5:0]   invInd;
   logic         invWay;
   logic [11:0]  snoopAddr;
   logic         snoopValid;
   logic [31:0]  memRdAddr;
   logic         memRdReq;
   logic         memRdValid;
   logic [63:0]  memRdData;
   logic         reqDropped;

   int passCnt  = 0;
   int totalCnt = 0;

   logic [11:0]  respQ[$];
   logic [255:0] respDataQ[$];

   icache_mem_responder #(
      .QUEUE_DEPTH (4),
      .MEM_DATA_W  (64)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .ic2memReqAddr_i   (reqAddr),
      .ic2memReqValid_i  (reqValid),
      .mem2icTag_o       (respTag),
      .mem2icIndex_o     (respIndex),
      .mem2icData_o      (respData),
      .mem2icRespValid_o (respValid),
      .mem2icInv_o       (inv),
      .mem2icInvInd_o    (invInd),
      .mem2icInvWay_o    (invWay),
      .snoopWrAddr_i     (snoopAddr),
      .snoopWrValid_i    (snoopValid),
      .memRdAddr_o       (memRdAddr),
      .memRdReq_o        (memRdReq),
      .memRdValid_i      (memRdValid),
      .memRdData_i       (memRdData),
      .reqDropped_o      (reqDropped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign memRdData = {memRdAddr ^ 32'hA5A5_0000, memRdAddr};

   // Record every response on the falling edge.
   always @(negedge clk) begin
      if (respValid) begin
         respQ.push_back({respTag, respIndex});
         respDataQ.push_back(respData);
      end
   end

   function automatic logic [255:0] expLine(input logic [11:0] a);
      logic [255:0] l;
      logic [31:0]  ba;
      l = '0;
      for (int b = 0; b < 4; b++) begin
         ba = {15'b0, a, 5'b0} + 32'(b * 8);
         l[b*64 +: 64] = {ba ^ 32'hA5A5_0000, ba};
      end
      return l;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sendReq(input logic [11:0] a);
      reqAddr  = a;
      reqValid = 1'b1;
      tick();
      reqValid = 1'b0;
   endtask

   task automatic doReset();
      reqValid   = 1'b0;
      snoopValid = 1'b0;
      reset      = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      respQ.delete();
      respDataQ.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      totalCnt++;
      if ({respValid, inv, invWay, memRdReq, reqDropped} !== 5'b0)
         $display("FAIL reset_strobes got=%b want=00000", {respValid, inv, invWay, memRdReq, reqDropped});
      else passCnt++;
      totalCnt++;
      if ({respTag, respIndex, invInd, memRdAddr} !== 50'b0)
         $display("FAIL reset_fields got=%h want=0", {respTag, respIndex, invInd, memRdAddr});
      else passCnt++;
      totalCnt++;
      if (respData !== 256'b0) $display("FAIL reset_data got=%h want=0", respData);
      else passCnt++;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single_line();
      int n;
      doReset();
      memRdValid = 1'b1;
      sendReq(12'h1A3);
      n = 1;
      tick();
      n++;
      totalCnt++;
      if (memRdReq !== 1'b1 || memRdAddr !== 32'h0000_3460)
         $display("FAIL first_beat_addr got=%b/%h want=1/00003460", memRdReq, memRdAddr);
      else passCnt++;
      while (!respValid && n < 20) begin
         tick();
         n++;
      end
      totalCnt++;
      if (n !== 6) $display("FAIL latency got=%0d want=6", n);
      else passCnt++;
      totalCnt++;
      if (respTag !== 6'h06 || respIndex !== 6'h23)
         $display("FAIL tag_index got=%h/%h want=06/23", respTag, respIndex);
      else passCnt++;
      totalCnt++;
      if (respData !== expLine(12'h1A3))
         $display("FAIL line_data got=%h want=%h", respData, expLine(12'h1A3));
      else passCnt++;
      tick();
      totalCnt++;
      if (respValid !== 1'b0) $display("FAIL resp_one_cycle got=%b want=0", respValid);
      else passCnt++;
   endtask

   task automatic test_queue_full();
      doReset();
      memRdValid = 1'b0;
      sendReq(12'h100);
      tick();
      for (int i = 1; i <= 4; i++) begin
         reqAddr  = 12'h100 + 12'(i);
         reqValid = 1'b1;
         tick();
      end
      totalCnt++;
      if (reqDropped !== 1'b0) $display("FAIL no_drop_at_four got=%b want=0", reqDropped);
      else passCnt++;
      reqAddr = 12'h105;
      tick();
      reqValid = 1'b0;
      totalCnt++;
      if (reqDropped !== 1'b1) $display("FAIL drop_on_fifth got=%b want=1", reqDropped);
      else passCnt++;
      memRdValid = 1'b1;
      repeat (60) tick();
      totalCnt++;
      if (respQ.size() !== 5) $display("FAIL resp_count_full got=%0d want=5", respQ.size());
      else passCnt++;
      for (int i = 0; i < 5; i++) begin
         if (i < respQ.size()) begin
            totalCnt++;
            if (respQ[i] !== 12'h100 + 12'(i))
               $display("FAIL fifo_order[%0d] got=%h want=%h", i, respQ[i], 12'h100 + 12'(i));
            else passCnt++;
         end
      end
      totalCnt++;
      if (reqDropped !== 1'b1) $display("FAIL drop_sticky got=%b want=1", reqDropped);
      else passCnt++;
   endtask

   task automatic test_duplicate();
      doReset();
      memRdValid = 1'b1;
      reqAddr    = 12'h040;
      reqValid   = 1'b1;
      tick();
      tick();
      reqValid = 1'b0;
      repeat (30) tick();
      totalCnt++;
      if (respQ.size() !== 1) $display("FAIL dup_count got=%0d want=1", respQ.size());
      else passCnt++;
      if (respQ.size() > 0) begin
         totalCnt++;
         if (respQ[0] !== 12'h040) $display("FAIL dup_addr got=%h want=040", respQ[0]);
         else passCnt++;
      end
   endtask

   task automatic test_reset_mid_line();
      doReset();
      memRdValid = 1'b1;
      sendReq(12'h0AB);
      tick();
      tick();
      totalCnt++;
      if (memRdAddr !== 32'h0000_1568) $display("FAIL beat1_addr got=%h want=00001568", memRdAddr);
      else passCnt++;
      reset = 1'b1;
      #1;
      totalCnt++;
      if ({respValid, memRdReq, memRdAddr, respData} !== 290'b0)
         $display("FAIL mid_reset_outputs got=%b/%b/%h want=0/0/0", respValid, memRdReq, memRdAddr);
      else passCnt++;
      tick();
      reset = 1'b0;
      respQ.delete();
      respDataQ.delete();
      repeat (15) tick();
      totalCnt++;
      if (respQ.size() !== 0) $display("FAIL abandoned_line got=%0d want=0", respQ.size());
      else passCnt++;
      sendReq(12'h0CD);
      tick();
      totalCnt++;
      if (memRdReq !== 1'b1 || memRdAddr !== 32'h0000_19A0)
         $display("FAIL restart_beat0 got=%b/%h want=1/000019a0", memRdReq, memRdAddr);
      else passCnt++;
      repeat (10) tick();
      totalCnt++;
      if (respQ.size() !== 1) $display("FAIL restart_count got=%0d want=1", respQ.size());
      else passCnt++;
      if (respDataQ.size() > 0) begin
         totalCnt++;
         if (respDataQ[0] !== expLine(12'h0CD))
            $display("FAIL restart_data got=%h want=%h", respDataQ[0], expLine(12'h0CD));
         else passCnt++;
      end
   endtask

   task automatic test_snoop();
      doReset();
      memRdValid = 1'b1;
      sendReq(12'h040);
      tick();
      tick();
      tick();
      totalCnt++;
      if (memRdAddr !== 32'h0000_0810) $display("FAIL beat2_addr got=%h want=00000810", memRdAddr);
      else passCnt++;
      snoopAddr  = 12'h040;
      snoopValid = 1'b1;
      tick();
      snoopValid = 1'b0;
`ifdef ICMEM_SNOOP_INV_EN
      totalCnt++;
      if (inv !== 1'b1 || invInd !== 6'h00 || invWay !== 1'b0)
         $display("FAIL snoop_inv got=%b/%h/%b want=1/00/0", inv, invInd, invWay);
      else passCnt++;
      tick();
      totalCnt++;
      if (inv !== 1'b0) $display("FAIL snoop_inv_pulse got=%b want=0", inv);
      else passCnt++;
      repeat (15) tick();
      totalCnt++;
      if (respQ.size() !== 0) $display("FAIL poisoned_resp got=%0d want=0", respQ.size());
      else passCnt++;
      snoopAddr  = 12'h1A3;
      snoopValid = 1'b1;
      tick();
      snoopValid = 1'b0;
      totalCnt++;
      if (inv !== 1'b1 || invInd !== 6'h23)
         $display("FAIL idle_snoop_inv got=%b/%h want=1/23", inv, invInd);
      else passCnt++;
`else
      totalCnt++;
      if (inv !== 1'b0 || invInd !== 6'h00)
         $display("FAIL snoop_ignored got=%b/%h want=0/00", inv, invInd);
      else passCnt++;
      repeat (15) tick();
      totalCnt++;
      if (respQ.size() !== 1) $display("FAIL snoop_no_poison got=%0d want=1", respQ.size());
      else passCnt++;
`endif
   endtask

   initial begin
      reset      = 1'b1;
      reqAddr    = '0;
      reqValid   = 1'b0;
      snoopAddr  = '0;
      snoopValid = 1'b0;
      memRdValid = 1'b0;
      test_reset();
      test_single_line();
      test_queue_full();
      test_duplicate();
      test_reset_mid_line();
      test_snoop();
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
